// File: rtl/ahb_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_mem_slave
//
// AHB-Lite slave memory model. It holds a word-addressed array and serves
// I-cache refill bursts and preload writes. Each OKAY transfer gets a fixed
// number of wait states. Size, alignment, range and burst sequencing are
// checked when the address phase is captured. A violation produces the
// two-cycle ERROR response.
//
// Ports
//   hclk        bus clock; all logic runs on the rising edge
//   hrstn       asynchronous active-low reset
//   hselx       slave select
//   haddr       transfer byte address
//   hwrite      1 = write, 0 = read
//   hsize       0 = byte, 1 = halfword, 2 = word (larger sizes are errors)
//   hburst      SINGLE/INCR/WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16
//   hport       protection info (unused)
//   htrans      IDLE/BUSY/NONSEQ/SEQ
//   hmastlock   locked transfer (unused)
//   hready_in   bus-level ready; an address phase counts only when high
//   hwdata      write data, sampled in the completing data-phase cycle
//   hready      transfer completion (registered)
//   hresp       0 = OKAY, 1 = ERROR (registered)
//   hrdata      read data; non-zero only in the DONE cycle of a read
//   dbg_state_o current FSM state, for observation only
//
// Handshake: an address phase is accepted on a rising edge when
// hselx & hready_in & htrans[1] are high and this slave drives hready high.
// The data phase that follows ends on the first rising edge where hready is
// high. A transfer that is accepted cannot be withdrawn. hselx may drop during
// the data phase, and the transfer still completes.
// ---------------------------------------------------------------------------
module ahb_lite_mem_slave #(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int WAIT_STATES     = 1
) (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic        hselx,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hport,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic        hready_in,
  input  logic [31:0] hwdata,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [2:0]  dbg_state_o
);

  localparam int          AW        = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Memory contents are not reset.
  logic [31:0] mem_q [MEM_DEPTH_WORDS];

  state_e      state_q;
  logic        hready_q;
  logic        hresp_q;
  logic [31:0] hrdata_q;
  logic [3:0]  cnt_q;

  // Attributes of the transfer that is currently in its data phase
  logic [31:0] addr_q;
  logic        write_q;
  logic [1:0]  size_q;

  // Burst tracker: the last accepted beat of the current burst
  logic        trk_valid_q;
  logic [31:0] trk_addr_q;
  logic [1:0]  trk_size_q;
  logic [2:0]  trk_burst_q;

  logic        unused_sigs;
  assign unused_sigs = ^{hport, hmastlock};

  // -------------------------------------------------------------------------
  // Address-phase capture and error checks
  // -------------------------------------------------------------------------
  logic        cap;
  logic        err_size;
  logic        err_align;
  logic        err_range;
  logic        err_seq;
  logic        cap_err;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic [4:0]  wrap_lg;
  logic        trk_wrap;
  logic [31:0] exp_addr;

  // hready_q is included as a gate so that a mis-wired hready_in cannot
  // start a new transfer while this slave is stalling.
  assign cap = hselx & hready_in & htrans[1] & hready_q;

  always_comb begin
    incr_addr = trk_addr_q + (32'd1 << trk_size_q);
    // The wrap block is beats * bytes-per-beat. Beats is 4/8/16, which is
    // hburst[2:1] + 1 as a log2 value for WRAP4/8/16.
    wrap_lg   = {3'b000, trk_burst_q[2:1]} + 5'd1 + {3'b000, trk_size_q};
    wrap_mask = (32'd1 << wrap_lg) - 32'd1;
    trk_wrap  = !trk_burst_q[0] && (trk_burst_q != 3'b000);
    exp_addr  = trk_wrap ? ((trk_addr_q & ~wrap_mask) | (incr_addr & wrap_mask))
                         : incr_addr;
  end

  always_comb begin
    err_size  = (hsize > 3'd2);
    err_align = ((hsize == 3'd1) && haddr[0]) ||
                ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    err_range = ({1'b0, haddr} >= MEM_BYTES);
    // A SEQ beat must follow a NONSEQ in a multi-beat burst and must land
    // exactly on the predicted address.
    err_seq   = htrans[0] && (!trk_valid_q || (trk_burst_q == 3'b000) ||
                              (haddr != exp_addr));
    cap_err   = err_size | err_align | err_range | err_seq;
  end

  // -------------------------------------------------------------------------
  // Write merge and read path with forwarding
  // -------------------------------------------------------------------------
  logic [AW-1:0] wr_word;
  logic [3:0]    wr_be;
  logic [31:0]   wr_merged;
  logic          wr_commit;
  logic [AW-1:0] rd_word;
  logic [31:0]   rd_data;

  assign wr_word   = addr_q[AW+1:2];
  assign wr_commit = (state_q == ST_DONE) && write_q;

  always_comb begin
    unique case (size_q)
      2'd0:    wr_be = 4'b0001 << addr_q[1:0];
      2'd1:    wr_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
    wr_merged = mem_q[wr_word];
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) wr_merged[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  // Read data is registered on the edge that enters DONE. From WAIT that is
  // the latched address. On a direct capture (WAIT_STATES=0) it is the live
  // address. If a write commits on that same edge to the same word, the
  // merged word is forwarded so the read returns the value after the write.
  always_comb begin
    rd_word = (state_q == ST_WAIT) ? addr_q[AW+1:2] : haddr[AW+1:2];
    rd_data = (wr_commit && (wr_word == rd_word)) ? wr_merged : mem_q[rd_word];
  end

  always_ff @(posedge hclk) begin
    if (wr_commit) mem_q[wr_word] <= wr_merged;
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered bus outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q     <= ST_IDLE;
      hready_q    <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'h0;
      cnt_q       <= 4'd0;
      addr_q      <= 32'h0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      trk_valid_q <= 1'b0;
      trk_addr_q  <= 32'h0;
      trk_size_q  <= 2'd0;
      trk_burst_q <= 3'd0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= ST_DONE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= write_q ? 32'h0 : rd_data;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          // IDLE, DONE and ERR2 all drive hready high, so each can accept
          // the next address phase.
          if (cap) begin
            if (cap_err) begin
              state_q  <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
              hrdata_q <= 32'h0;
            end else begin
              addr_q  <= haddr;
              write_q <= hwrite;
              size_q  <= hsize[1:0];
              if (WAIT_STATES == 0) begin
                state_q  <= ST_DONE;
                hready_q <= 1'b1;
                hresp_q  <= 1'b0;
                hrdata_q <= hwrite ? 32'h0 : rd_data;
              end else begin
                state_q  <= ST_WAIT;
                hready_q <= 1'b0;
                hresp_q  <= 1'b0;
                hrdata_q <= 32'h0;
                cnt_q    <= WS_LOAD;
              end
            end
          end else begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= 32'h0;
          end
        end
      endcase

      // The tracker moves only on accepted NONSEQ/SEQ beats, so BUSY
      // cycles leave it unchanged. An error cancels the rest of the burst.
      if (cap) begin
        if (cap_err) begin
          trk_valid_q <= 1'b0;
        end else begin
          trk_valid_q <= 1'b1;
          trk_addr_q  <= haddr;
          if (!htrans[0]) begin
            trk_size_q  <= hsize[1:0];
            trk_burst_q <= hburst;
          end
        end
      end
    end
  end

  assign hready      = hready_q;
  assign hresp       = hresp_q;
  assign hrdata      = hrdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
module tb_ahb_lite_mem_slave;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_WRAP4 = 3'd2, B_INCR4 = 3'd3;

  // ---- clock / reset ----
  logic hclk;
  logic hrstn;
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---- shared bus stimulus; use0 routes the select to the zero-wait instance ----
  logic        use0;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;

  logic        hready1, hresp1, hready0, hresp0;
  logic [31:0] hrdata1, hrdata0;
  logic [2:0]  dbg1, dbg0;
  logic        bus_hready, bus_hresp;
  logic [31:0] bus_hrdata;

  assign bus_hready = use0 ? hready0 : hready1;
  assign bus_hresp  = use0 ? hresp0  : hresp1;
  assign bus_hrdata = use0 ? hrdata0 : hrdata1;

  ahb_lite_mem_slave #(.MEM_DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_ws1 (
    .hclk(hclk), .hrstn(hrstn), .hselx(hsel & ~use0), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hport(4'h3),
    .htrans(htrans), .hmastlock(1'b0), .hready_in(hready1), .hwdata(hwdata),
    .hready(hready1), .hresp(hresp1), .hrdata(hrdata1), .dbg_state_o(dbg1)
  );

  ahb_lite_mem_slave #(.MEM_DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_ws0 (
    .hclk(hclk), .hrstn(hrstn), .hselx(hsel & use0), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hport(4'h3),
    .htrans(htrans), .hmastlock(1'b0), .hready_in(hready0), .hwdata(hwdata),
    .hready(hready0), .hresp(hresp0), .hrdata(hrdata0), .dbg_state_o(dbg0)
  );

  int checks = 0;
  int errors = 0;

  // ---- beat table and per-beat observations ----
  int          n_beats;
  logic [1:0]  tr_trans [16];
  logic [31:0] tr_addr  [16];
  logic        tr_write [16];
  logic [2:0]  tr_size  [16];
  logic [2:0]  tr_burst [16];
  logic [31:0] tr_wdata [16];
  logic [31:0] rs_rdata [16];
  logic        rs_resp  [16];
  logic        rs_lowresp [16];
  int          rs_waits [16];

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = T_IDLE; haddr = 32'h0; hwrite = 1'b0;
    hsize = 3'd0; hburst = B_SINGLE; hwdata = 32'h0;
  endtask

  task automatic add_beat(input logic [1:0] t, input logic [31:0] a, input logic w,
                          input logic [2:0] s, input logic [2:0] b, input logic [31:0] d);
    tr_trans[n_beats] = t; tr_addr[n_beats] = a; tr_write[n_beats] = w;
    tr_size[n_beats] = s; tr_burst[n_beats] = b; tr_wdata[n_beats] = d;
    n_beats++;
  endtask

  // Drives the beat table as a pipelined master. Each beat records its wait
  // cycles, the hresp seen while hready was low, and rdata/hresp at completion.
  task automatic run_seq();
    int i;
    int dp;
    int budget;
    i = 0; dp = -1; budget = 0;
    for (int k = 0; k < 16; k++) begin
      rs_rdata[k] = 32'h0; rs_resp[k] = 1'b0; rs_lowresp[k] = 1'b0; rs_waits[k] = 0;
    end
    while ((i < n_beats || dp >= 0) && budget < 200) begin
      if (i < n_beats) begin
        hsel = 1'b1; htrans = tr_trans[i]; haddr = tr_addr[i]; hwrite = tr_write[i];
        hsize = tr_size[i]; hburst = tr_burst[i];
      end else begin
        hsel = 1'b0; htrans = T_IDLE; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'd0; hburst = B_SINGLE;
      end
      hwdata = (dp >= 0 && tr_write[dp]) ? tr_wdata[dp] : 32'h0;
      if (dp >= 0) begin
        if (bus_hready) begin
          rs_rdata[dp] = bus_hrdata; rs_resp[dp] = bus_hresp; dp = -1;
        end else begin
          rs_waits[dp]++; rs_lowresp[dp] = bus_hresp;
        end
      end
      if (bus_hready && i < n_beats) begin
        if (tr_trans[i][1]) dp = i;
        i++;
      end
      cyc();
      budget++;
    end
    checks++;
    if (budget >= 200) begin
      errors++;
      $display("FAIL run_seq_timeout: got %0d cycles, need < 200", budget);
    end
    bus_idle();
    cyc();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    use0 = 1'b0; bus_idle(); hrstn = 1'b0;
    cyc(); cyc();
    checks++; if (hready1 !== 1'b1) begin errors++; $display("FAIL reset_hready1: got %b exp 1", hready1); end
    checks++; if (hresp1 !== 1'b0) begin errors++; $display("FAIL reset_hresp1: got %b exp 0", hresp1); end
    checks++; if (hrdata1 !== 32'h0) begin errors++; $display("FAIL reset_hrdata1: got %h exp 0", hrdata1); end
    checks++; if (dbg1 !== 3'd0) begin errors++; $display("FAIL reset_state1: got %0d exp 0", dbg1); end
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL reset_hready0: got %b exp 1", hready0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL reset_hresp0: got %b exp 0", hresp0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL reset_hrdata0: got %h exp 0", hrdata0); end
    hrstn = 1'b1;
    cyc();
  endtask

  task automatic test_single_read();
    n_beats = 0;
    add_beat(T_NSEQ, 32'h10, 1'b1, 3'd2, B_SINGLE, 32'hDEADBEEF);
    add_beat(T_NSEQ, 32'h10, 1'b0, 3'd2, B_SINGLE, 32'h0);
    run_seq();
    checks++; if (rs_resp[0] !== 1'b0) begin errors++; $display("FAIL single_wr_resp: got %b exp 0", rs_resp[0]); end
    checks++; if (rs_waits[1] != 1) begin errors++; $display("FAIL single_rd_waits: got %0d exp 1", rs_waits[1]); end
    checks++; if (rs_rdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_data: got %h exp deadbeef", rs_rdata[1]); end
    checks++; if (rs_resp[1] !== 1'b0) begin errors++; $display("FAIL single_rd_resp: got %b exp 0", rs_resp[1]); end
  endtask

  task automatic test_incr_wrap();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h44; exp_rd[1] = 32'h11; exp_rd[2] = 32'h22; exp_rd[3] = 32'h33;
    n_beats = 0;
    add_beat(T_NSEQ, 32'h00, 1'b1, 3'd2, B_INCR4, 32'h11);
    add_beat(T_SEQ,  32'h04, 1'b1, 3'd2, B_INCR4, 32'h22);
    add_beat(T_SEQ,  32'h08, 1'b1, 3'd2, B_INCR4, 32'h33);
    add_beat(T_SEQ,  32'h0C, 1'b1, 3'd2, B_INCR4, 32'h44);
    run_seq();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rs_resp[k] !== 1'b0 || rs_waits[k] != 1) begin
        errors++; $display("FAIL incr4_wr beat %0d: got resp %b waits %0d exp 0/1", k, rs_resp[k], rs_waits[k]);
      end
    end
    n_beats = 0;
    add_beat(T_NSEQ, 32'h0C, 1'b0, 3'd2, B_WRAP4, 32'h0);
    add_beat(T_SEQ,  32'h00, 1'b0, 3'd2, B_WRAP4, 32'h0);
    add_beat(T_SEQ,  32'h04, 1'b0, 3'd2, B_WRAP4, 32'h0);
    add_beat(T_SEQ,  32'h08, 1'b0, 3'd2, B_WRAP4, 32'h0);
    run_seq();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rs_rdata[k] !== exp_rd[k] || rs_resp[k] !== 1'b0) begin
        errors++; $display("FAIL wrap4_rd beat %0d: got %h resp %b exp %h resp 0", k, rs_rdata[k], rs_resp[k], exp_rd[k]);
      end
    end
  endtask

  task automatic test_byte_write();
    n_beats = 0;
    add_beat(T_NSEQ, 32'h04, 1'b1, 3'd2, B_SINGLE, 32'hAABBCCDD);
    add_beat(T_NSEQ, 32'h05, 1'b1, 3'd0, B_SINGLE, 32'h0000EE00);
    add_beat(T_NSEQ, 32'h04, 1'b0, 3'd2, B_SINGLE, 32'h0);
    add_beat(T_NSEQ, 32'h06, 1'b1, 3'd1, B_SINGLE, 32'h12340000);
    add_beat(T_NSEQ, 32'h04, 1'b0, 3'd2, B_SINGLE, 32'h0);
    run_seq();
    checks++; if (rs_rdata[2] !== 32'hAABBEEDD) begin errors++; $display("FAIL byte_write: got %h exp aabbeedd", rs_rdata[2]); end
    checks++; if (rs_rdata[4] !== 32'h1234EEDD) begin errors++; $display("FAIL half_write: got %h exp 1234eedd", rs_rdata[4]); end
  endtask

  task automatic test_busy();
    n_beats = 0;
    add_beat(T_NSEQ, 32'h00, 1'b0, 3'd2, B_INCR4, 32'h0);
    add_beat(T_BUSY, 32'h04, 1'b0, 3'd2, B_INCR4, 32'h0);
    add_beat(T_SEQ,  32'h04, 1'b0, 3'd2, B_INCR4, 32'h0);
    run_seq();
    checks++; if (rs_rdata[0] !== 32'h11) begin errors++; $display("FAIL busy_beat0: got %h exp 11", rs_rdata[0]); end
    checks++;
    if (rs_rdata[2] !== 32'h1234EEDD || rs_resp[2] !== 1'b0) begin
      errors++; $display("FAIL busy_beat1: got %h resp %b exp 1234eedd resp 0", rs_rdata[2], rs_resp[2]);
    end
  endtask

  task automatic test_out_of_range();
    n_beats = 0;
    add_beat(T_NSEQ, 32'h1000, 1'b0, 3'd2, B_SINGLE, 32'h0);
    add_beat(T_NSEQ, 32'h0000, 1'b0, 3'd2, B_SINGLE, 32'h0);
    run_seq();
    checks++;
    if (rs_waits[0] != 1 || rs_lowresp[0] !== 1'b1) begin
      errors++; $display("FAIL oor_err1: got waits %0d hresp %b exp 1/1", rs_waits[0], rs_lowresp[0]);
    end
    checks++; if (rs_resp[0] !== 1'b1) begin errors++; $display("FAIL oor_err2: got hresp %b exp 1", rs_resp[0]); end
    checks++;
    if (rs_resp[1] !== 1'b0 || rs_rdata[1] !== 32'h11) begin
      errors++; $display("FAIL oor_next: got %h resp %b exp 11 resp 0", rs_rdata[1], rs_resp[1]);
    end
  endtask

  task automatic test_bad_seq();
    logic exp_resp [7];
    exp_resp[0] = 1'b0; exp_resp[1] = 1'b1; exp_resp[2] = 1'b1; exp_resp[3] = 1'b1;
    exp_resp[4] = 1'b1; exp_resp[5] = 1'b0; exp_resp[6] = 1'b0;
    n_beats = 0;
    add_beat(T_NSEQ, 32'h20,  1'b0, 3'd2, B_INCR4,  32'h0); // ok
    add_beat(T_SEQ,  32'h28,  1'b0, 3'd2, B_INCR4,  32'h0); // skipped 0x24
    add_beat(T_NSEQ, 32'h02,  1'b0, 3'd2, B_SINGLE, 32'h0); // misaligned word
    add_beat(T_SEQ,  32'h24,  1'b0, 3'd2, B_INCR4,  32'h0); // SEQ with no NONSEQ
    add_beat(T_NSEQ, 32'h00,  1'b0, 3'd3, B_SINGLE, 32'h0); // hsize too large
    add_beat(T_NSEQ, 32'hFFF, 1'b0, 3'd0, B_SINGLE, 32'h0); // last valid byte
    add_beat(T_NSEQ, 32'hFFC, 1'b0, 3'd2, B_SINGLE, 32'h0); // last valid word
    run_seq();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (rs_resp[k] !== exp_resp[k] || rs_lowresp[k] !== exp_resp[k]) begin
        errors++; $display("FAIL bad_seq beat %0d: got resp %b low %b exp %b", k, rs_resp[k], rs_lowresp[k], exp_resp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    n_beats = 0;
    add_beat(T_NSEQ, 32'h80, 1'b1, 3'd2, B_SINGLE, 32'h0);
    run_seq();
    hsel = 1'b1; htrans = T_NSEQ; haddr = 32'h80; hwrite = 1'b1; hsize = 3'd2; hburst = B_SINGLE;
    cyc();
    checks++; if (hready1 !== 1'b0) begin errors++; $display("FAIL mid_wait: got hready %b exp 0", hready1); end
    bus_idle(); hwdata = 32'hFFFFFFFF;
    hrstn = 1'b0;
    #1;
    checks++;
    if (hready1 !== 1'b1 || hresp1 !== 1'b0 || dbg1 !== 3'd0) begin
      errors++; $display("FAIL mid_reset: got hready %b hresp %b state %0d exp 1/0/0", hready1, hresp1, dbg1);
    end
    cyc(); cyc();
    hrstn = 1'b1;
    cyc();
    n_beats = 0;
    add_beat(T_NSEQ, 32'h80, 1'b0, 3'd2, B_SINGLE, 32'h0);
    run_seq();
    checks++; if (rs_rdata[0] !== 32'h0) begin errors++; $display("FAIL mid_discard: got %h exp 0", rs_rdata[0]); end
  endtask

  task automatic test_back_to_back();
    use0 = 1'b1;
    n_beats = 0;
    add_beat(T_NSEQ, 32'h40, 1'b1, 3'd2, B_SINGLE, 32'h12345678);
    add_beat(T_NSEQ, 32'h40, 1'b0, 3'd2, B_SINGLE, 32'h0);
    add_beat(T_NSEQ, 32'h41, 1'b1, 3'd0, B_SINGLE, 32'h0000AB00);
    add_beat(T_NSEQ, 32'h40, 1'b0, 3'd2, B_SINGLE, 32'h0);
    run_seq();
    checks++;
    if (rs_rdata[1] !== 32'h12345678 || rs_waits[1] != 0) begin
      errors++; $display("FAIL raw_word: got %h waits %0d exp 12345678/0", rs_rdata[1], rs_waits[1]);
    end
    checks++; if (rs_waits[0] != 0) begin errors++; $display("FAIL raw_wr_waits: got %0d exp 0", rs_waits[0]); end
    checks++; if (rs_rdata[3] !== 32'h1234AB78) begin errors++; $display("FAIL raw_byte: got %h exp 1234ab78", rs_rdata[3]); end
    use0 = 1'b0;
  endtask

  initial begin
    use0 = 1'b0; hrstn = 1'b0; n_beats = 0;
    bus_idle();
    test_reset();
    test_single_read();
    test_incr_wrap();
    test_byte_write();
    test_busy();
    test_out_of_range();
    test_bad_seq();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite slave memory model that sits on the slave side of the `ahb_lite` bus. It serves instruction-cache refill bursts and testbench preload writes.
- Internal word-addressed array; configurable wait states.
- Checks burst address sequencing and size/alignment, and returns a two-cycle ERROR response on any violation.
- Pairs with the I-cache refill master for integration and regression.

Parameters:
- MEM_DEPTH_WORDS, 1024, number of 32-bit words; valid byte range is 0 to MEM_DEPTH_WORDS*4-1.
- WAIT_STATES, 1, hready-low cycles inserted before each OKAY data-phase completion (0..15).

Ports:
- hclk  input  1  bus clock, all logic on rising edge
- hrstn  input  1  asynchronous active-low reset
- hselx  input  1  slave select
- haddr  input  32  transfer byte address
- hwrite  input  1  1=write, 0=read
- hsize  input  3  transfer size (0=byte, 1=half, 2=word)
- hburst  input  3  burst type: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
- hport  input  4  protection info, ignored
- htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hmastlock  input  1  ignored
- hready_in  input  1  bus-level ready; address phase is valid only when high
- hwdata  input  32  write data, sampled in the completing data-phase cycle
- hready  output  1  transfer completion
- hresp  output  1  0=OKAY, 1=ERROR
- hrdata  output  32  read data

Behaviour:
- Clock and reset: one clock, hclk. hrstn is asynchronous, active-low.
  - Reset values: hready=1, hresp=0, hrdata=0, state=IDLE, burst tracker cleared. Memory contents are not reset.
- Address-phase capture: when hselx & hready_in & htrans[1], latch haddr, hwrite, hsize, hburst. This starts a data phase on the next cycle.
  - IDLE or BUSY with hselx: zero-wait OKAY; no data-phase state change.
  - BUSY inside a burst holds the burst tracker.
- Error checks, evaluated at capture; any failure selects the ERROR path:
  - hsize > 2.
  - Misalignment: hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0.
  - haddr >= MEM_DEPTH_WORDS*4.
  - SEQ whose haddr differs from the expected next address.
- Expected next address:
  - Base is previous beat address + (1<<hsize).
  - WRAP4/8/16 wrap within an aligned block of beats*(1<<hsize) bytes.
  - INCR* and INCR: linear.
  - A SEQ with no preceding NONSEQ in the burst is an error.
- State machine:
  - IDLE: hready=1, hresp=0.
  - WAIT: entered on a valid capture when WAIT_STATES>0. Counter loads WAIT_STATES-1; hready=0 while counting; go to DONE when counter=0.
  - DONE: hready=1, hresp=0. Write commits or read data is driven this cycle. A new capture in this cycle pipelines directly into WAIT, DONE or ERR1; otherwise go to IDLE.
  - WAIT_STATES=0: a valid capture goes straight to DONE.
  - ERR1: hready=0, hresp=1, always one cycle, then ERR2.
  - ERR2: hready=1, hresp=1. No memory access. A new capture here is accepted normally.
  - After any error the burst tracker clears.
- Write:
  - Byte lanes are selected by hsize and haddr[1:0], little-endian: byte at addr[1:0]=n uses hwdata[8n+7:8n]; a halfword uses lanes 0-1 or 2-3.
  - Unselected bytes are unchanged.
- Read:
  - hrdata = full word at haddr[..:2], regardless of hsize, driven only in the DONE cycle of a read; 0 otherwise.
- Read-after-write: a read whose address phase coincides with the completing data phase of a write to the same word returns the post-write word. Forwarding is required when WAIT_STATES=0.
- Reset asserted mid-transfer: immediate return to IDLE with reset output values. A write not yet in DONE is discarded.
- hselx deasserted during a data phase: the transfer still completes.

Test Plan:
- Reset and single read, WAIT_STATES=1: assert hrstn low -> hready=1, hresp=0, hrdata=0. Preload word 0x10 = 0xDEADBEEF, then NONSEQ SINGLE read 0x10 -> one hready-low cycle, then hready=1 with hrdata=0xDEADBEEF.
- INCR4 then WRAP4: INCR4 word writes at 0x00..0x0C with data 0x11,0x22,0x33,0x44 -> all OKAY. Then WRAP4 read starting at 0x0C with SEQ addresses 0x00,0x04,0x08 -> hrdata 0x44,0x11,0x22,0x33, no ERROR.
- Byte write: word 0x04=0xAABBCCDD; hsize=0 write at 0x05 with hwdata=0x0000EE00 -> word reads back 0xAABBEEDD.
- Out-of-range read: with MEM_DEPTH_WORDS=1024, read at 0x1000 -> cycle 1 hready=0/hresp=1, cycle 2 hready=1/hresp=1. A following NONSEQ read of 0x0 accepted in cycle 2 completes OKAY.
- Bad SEQ: INCR4 from 0x20 whose second beat is SEQ 0x28 -> ERROR on that beat. Misaligned hsize=2 at 0x02 -> ERROR.
- Read-after-write, WAIT_STATES=0: back-to-back write 0x12345678 to 0x40 then read 0x40 -> read hrdata=0x12345678 with no wait cycles.
